truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

- Sequential stimulus-and-check stage that sits directly upstream of a pair of 3-input combinational function blocks: an SOP realisation and a POS realisation of the same function.
- It drives every input combination onto the shared inputs in ascending order and waits a programmable settle time. It then samples both function outputs and records them into two truth-table signatures.
- It flags, locates and counts any rows where the two realisations disagree.
- It replaces hand-written `#10` stimulus sequences with a reusable, clocked equivalence checker.

## Interface
- `N_IN`, 3, number of function inputs; legal 1..5; table depth is 2^N_IN rows.
- `SETTLE`, 1, cycles the input vector is held before sampling; legal 1..15.

- `clk` in 1: single clock, all state changes on rising edge.
- `reset` in 1: synchronous, active-high; clears all state on the next rising edge.
- `start` in 1: level-sampled in IDLE; begins a sweep.
- `vec` out N_IN: input vector to the function blocks. For N_IN=3: x=vec[2], y=vec[1], z=vec[0].
- `fs` in 1: SOP block output.
- `fp` in 1: POS block output.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: single-cycle pulse at the end of a sweep.
- `sig_s` out 2^N_IN: bit i = sampled `fs` with vec=i.
- `sig_p` out 2^N_IN: bit i = sampled `fp` with vec=i.
- `mismatch` out 1: sticky; any row with fs≠fp in the last sweep.
- `first_bad` out N_IN: lowest row index with fs≠fp; 0 if none.
- `mis_count` out N_IN+1: number of mismatching rows (0..2^N_IN).

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE. A settle counter counts down over SETTLE cycles; a row counter drives `vec`.
- **IDLE:** `busy`=0, `vec` holds 0.
  - On `start`=1, go to DRIVE.
  - On that same edge, set `vec`=0 and clear `sig_s`, `sig_p`, `mismatch`, `first_bad` and `mis_count`.
  - Load the settle counter with SETTLE.
- **DRIVE:** hold `vec` for SETTLE cycles, then go to SAMPLE.
- **SAMPLE:** one cycle.
  - Write `sig_s[vec]`←fs and `sig_p[vec]`←fp.
  - If fs≠fp: increment `mis_count`. If `mismatch` was 0, also load `first_bad`←vec. Then set `mismatch`=1.
  - If vec = 2^N_IN−1, go to DONE. Otherwise increment `vec`, reload the settle counter and go to DRIVE.
- **DONE:** one cycle. `done`=1, `busy`=0, `vec` is held at its final value. Next state is always IDLE, and `vec` returns to 0 on entry to IDLE.
- `start` is ignored in DRIVE, SAMPLE and DONE. With `start` held high, a new sweep begins on the first IDLE cycle after DONE.
- Results (`sig_*`, `mismatch`, `first_bad`, `mis_count`) remain stable from DONE until the next accepted `start`.
  - Mid-sweep values are partial and not meaningful; consumers qualify them with `done`.
- `mis_count` cannot overflow, since its maximum is 2^N_IN.

## Timing
- Reset values: state IDLE, `vec`=0, `busy`=0, `done`=0, `sig_s`=0, `sig_p`=0, `mismatch`=0, `first_bad`=0, `mis_count`=0, settle counter 0.
- `reset` asserted in any state (including mid-sweep) takes priority over `start` and all FSM activity. The sweep is abandoned with no `done` pulse.
- With `start` sampled high at edge E0:
  - `busy` rises after E0.
  - Row k is driven from edge E0+k·(SETTLE+1).
  - Row k is sampled at edge E0+k·(SETTLE+1)+SETTLE+1.
  - DONE is entered at edge E0+2^N_IN·(SETTLE+1), with `done`=1 for exactly that cycle.
  - For defaults: `done` is high after edge E0+16 and `busy` falls at that same edge.
- `fs`/`fp` must be valid SETTLE cycles after `vec` changes, because the function blocks are combinational.

## Test plan
- **Equivalence:** default params with the team's SOP (y | ~x~yz) and POS blocks attached; pulse `start`.
  - Required: `done` after 16 cycles, `sig_s`=8'hCE, `sig_p`=8'hCE, `mismatch`=0, `first_bad`=0, `mis_count`=0.
- **Fault injection:** fp model = fs inverted on row 5 only.
  - Required: `sig_p`=8'hEE, `mismatch`=1, `first_bad`=5, `mis_count`=1.
- **Multiple faults:** fp = ~fs on rows 2, 6 and 7.
  - Required: `first_bad`=2, `mis_count`=3.
  - Then run a second sweep with a correct fp: all flags clear, `mis_count`=0.
- **Reset mid-sweep:** assert `reset` for one cycle at E0+7.
  - Required: on the next edge `busy`=0, `vec`=0, `sig_s`=0, and no `done` pulse ever follows.
- **Start handling:** hold `start` high continuously.
  - Required: back-to-back sweeps with one IDLE cycle between them.
  - Also required: a `start` pulse asserted during DRIVE is ignored, so `done` is still at E0+16.
- **Parameter corners:** SETTLE=3 with N_IN=3.
  - Required: `done` at E0+32, and `vec` is stable for 3 cycles before each sample.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Clocked equivalence checker for two realisations of the same function.
// It steps every input combination onto vec in ascending order. It holds each
// row for SETTLE cycles, then samples both block outputs into a truth-table
// signature and records any rows where the two outputs disagree.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      level-sampled in IDLE; begins a sweep
//   vec        input vector to the function blocks under test
//   fs, fp     outputs of the SOP and POS blocks
//   busy       high while a sweep is in progress (DRIVE/SAMPLE)
//   done       single-cycle pulse when a sweep finishes
//   sig_s      bit i = sampled fs with vec=i
//   sig_p      bit i = sampled fp with vec=i
//   mismatch   any row with fs != fp in the last sweep
//   first_bad  lowest mismatching row index, 0 if none
//   mis_count  number of mismatching rows
//
// State table
//   S_IDLE   | waiting for start, vec held at 0
//   S_DRIVE  | vec held, settle counter counting down
//   S_SAMPLE | capture fs/fp for current row, advance or finish
//   S_DONE   | one-cycle done pulse, results frozen
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [N_IN-1:0]        vec,
    input  logic                   fs,
    input  logic                   fp,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   sig_s,
    output logic [(1<<N_IN)-1:0]   sig_p,
    output logic                   mismatch,
    output logic [N_IN-1:0]        first_bad,
    output logic [N_IN:0]          mis_count
);

    localparam int               ROWS      = 1 << N_IN;
    localparam logic [N_IN-1:0]  LAST_ROW  = '1;
    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              state_q,     state_d;
    logic [N_IN-1:0]     vec_q,       vec_d;
    logic [3:0]          settle_q,    settle_d;
    logic [ROWS-1:0]     sig_s_q,     sig_s_d;
    logic [ROWS-1:0]     sig_p_q,     sig_p_d;
    logic                mismatch_q,  mismatch_d;
    logic [N_IN-1:0]     first_bad_q, first_bad_d;
    logic [N_IN:0]       mis_count_q, mis_count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            settle_q    <= '0;
            sig_s_q     <= '0;
            sig_p_q     <= '0;
            mismatch_q  <= 1'b0;
            first_bad_q <= '0;
            mis_count_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            settle_q    <= settle_d;
            sig_s_q     <= sig_s_d;
            sig_p_q     <= sig_p_d;
            mismatch_q  <= mismatch_d;
            first_bad_q <= first_bad_d;
            mis_count_q <= mis_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        settle_d    = settle_q;
        sig_s_d     = sig_s_q;
        sig_p_d     = sig_p_q;
        mismatch_d  = mismatch_q;
        first_bad_d = first_bad_q;
        mis_count_d = mis_count_q;

        case (state_q)
            S_IDLE: begin
                vec_d = '0;
                if (start) begin
                    state_d     = S_DRIVE;
                    settle_d    = SETTLE_LD;
                    sig_s_d     = '0;
                    sig_p_d     = '0;
                    mismatch_d  = 1'b0;
                    first_bad_d = '0;
                    mis_count_d = '0;
                end
            end
            S_DRIVE: begin
                // Terminal count at 1: DRIVE lasts exactly SETTLE cycles.
                if (settle_q <= 4'd1) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                sig_s_d[vec_q] = fs;
                sig_p_d[vec_q] = fp;
                if (fs != fp) begin
                    mis_count_d = mis_count_q + (N_IN+1)'(1);
                    if (!mismatch_q) begin
                        first_bad_d = vec_q;
                    end
                    mismatch_d = 1'b1;
                end
                if (vec_q == LAST_ROW) begin
                    state_d = S_DONE;
                end else begin
                    vec_d    = vec_q + N_IN'(1);
                    settle_d = SETTLE_LD;
                    state_d  = S_DRIVE;
                end
            end
            S_DONE: begin
                // vec stays at the last row for this cycle, clears on entry to IDLE.
                state_d = S_IDLE;
                vec_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign vec       = vec_q;
    assign busy      = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done      = (state_q == S_DONE);
    assign sig_s     = sig_s_q;
    assign sig_p     = sig_p_q;
    assign mismatch  = mismatch_q;
    assign first_bad = first_bad_q;
    assign mis_count = mis_count_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper
// Directed bench for truth_table_sweeper. The SOP (y | ~x~y z) and POS
// ((y|z)(~x|y)) blocks are modelled combinationally. Faults are planted by
// XOR-ing a per-row mask onto fp. A second instance runs with SETTLE=3.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start, start3;
    logic [2:0] vec, vec3;
    logic       fs, fp, fs3, fp3;
    logic       busy, done, busy3, done3;
    logic [7:0] sig_s, sig_p, sig_s3, sig_p3;
    logic       mismatch, mismatch3;
    logic [2:0] first_bad, first_bad3;
    logic [3:0] mis_count, mis_count3;
    logic [7:0] fault_mask;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic sop_f(input logic [2:0] v);
        return v[1] | (~v[2] & ~v[1] & v[0]);
    endfunction

    function automatic logic pos_f(input logic [2:0] v);
        return (v[1] | v[0]) & (~v[2] | v[1]);
    endfunction

    assign fs  = sop_f(vec);
    assign fp  = pos_f(vec) ^ fault_mask[vec];
    assign fs3 = sop_f(vec3);
    assign fp3 = pos_f(vec3);

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .vec(vec), .fs(fs), .fp(fp),
        .busy(busy), .done(done), .sig_s(sig_s), .sig_p(sig_p),
        .mismatch(mismatch), .first_bad(first_bad), .mis_count(mis_count)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .vec(vec3), .fs(fs3), .fp(fp3),
        .busy(busy3), .done(done3), .sig_s(sig_s3), .sig_p(sig_p3),
        .mismatch(mismatch3), .first_bad(first_bad3), .mis_count(mis_count3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts edges from E0 until done is seen #1 after an edge; bounded.
    task automatic wait_done(input int which, input int lat0, output int lat);
        lat = lat0;
        while (((which == 0) ? done : done3) !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Pulses start so it is sampled at E0, then returns #1 after E0.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_sweep(input string tag);
        int lat;
        pulse_start();
        chk({tag, "_busy_rise"}, busy, 1);
        wait_done(0, 0, lat);
        chk({tag, "_done_lat"}, lat, 16);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_vec_at_done"}, vec, 7);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_vec_idle"}, vec, 0);
    endtask

    initial begin
        int lat;
        int n_done;
        reset      = 1'b1;
        start      = 1'b0;
        start3     = 1'b0;
        fault_mask = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_vec",       vec, 0);
        chk("rst_busy",      busy, 0);
        chk("rst_done",      done, 0);
        chk("rst_sig_s",     sig_s, 0);
        chk("rst_sig_p",     sig_p, 0);
        chk("rst_mismatch",  mismatch, 0);
        chk("rst_first_bad", first_bad, 0);
        chk("rst_mis_count", mis_count, 0);

        // Equivalent blocks.
        run_sweep("eq");
        chk("eq_sig_s",     sig_s, 8'hCE);
        chk("eq_sig_p",     sig_p, 8'hCE);
        chk("eq_mismatch",  mismatch, 0);
        chk("eq_first_bad", first_bad, 0);
        chk("eq_mis_count", mis_count, 0);

        // Single fault on row 5.
        fault_mask = 8'h20;
        run_sweep("f5");
        chk("f5_sig_s",     sig_s, 8'hCE);
        chk("f5_sig_p",     sig_p, 8'hEE);
        chk("f5_mismatch",  mismatch, 1);
        chk("f5_first_bad", first_bad, 5);
        chk("f5_mis_count", mis_count, 1);

        // Faults on rows 2, 6, 7.
        fault_mask = 8'hC4;
        run_sweep("f267");
        chk("f267_sig_p",     sig_p, 8'h0A);
        chk("f267_mismatch",  mismatch, 1);
        chk("f267_first_bad", first_bad, 2);
        chk("f267_mis_count", mis_count, 3);

        // Clean sweep afterwards clears everything.
        fault_mask = 8'h00;
        run_sweep("clean");
        chk("clean_sig_p",     sig_p, 8'hCE);
        chk("clean_mismatch",  mismatch, 0);
        chk("clean_first_bad", first_bad, 0);
        chk("clean_mis_count", mis_count, 0);

        // Reset sampled at E0+7 abandons the sweep.
        pulse_start();
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mrst_busy",  busy, 0);
        chk("mrst_vec",   vec, 0);
        chk("mrst_sig_s", sig_s, 0);
        chk("mrst_mis_count", mis_count, 0);
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("mrst_no_done", n_done, 0);
        chk("mrst_still_idle", busy, 0);

        // Start pulse during DRIVE is ignored.
        pulse_start();
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(0, 3, lat);
        chk("drvstart_done_lat", lat, 16);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("drvstart_no_restart", busy, 0);

        // Start held high: back-to-back sweeps with one IDLE cycle.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        chk("hold_busy_rise", busy, 1);
        wait_done(0, 0, lat);
        chk("hold_done_lat1", lat, 16);
        @(posedge clk); #1;
        chk("hold_idle_busy", busy, 0);
        chk("hold_idle_done", done, 0);
        @(posedge clk); #1;
        chk("hold_restart_busy", busy, 1);
        wait_done(0, 0, lat);
        start = 1'b0;
        chk("hold_done_lat2", lat, 16);
        chk("hold_sig_s2", sig_s, 8'hCE);
        repeat (3) @(posedge clk);
        #1 chk("hold_stop_busy", busy, 0);

        // SETTLE=3: each row held 4 edges, done at E0+32.
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int e = 0; e < 32; e++) begin
            logic [2:0] expv;
            expv = 3'(e / 4);
            chk($sformatf("s3_vec_e%0d", e), vec3, expv);
            if (e == 31) chk("s3_done_early", done3, 0);
            @(posedge clk); #1;
        end
        chk("s3_done_lat", done3, 1);
        chk("s3_busy_done", busy3, 0);
        chk("s3_sig_s", sig_s3, 8'hCE);
        chk("s3_sig_p", sig_p3, 8'hCE);
        chk("s3_mis_count", mis_count3, 0);
        @(posedge clk); #1;
        chk("s3_done_pulse", done3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
